meas_result_packer: RTL and testbench

MEAS_RESULT_PACKER -- requirements
Module: meas_result_packer

---
 rtl/meas_result_packer.sv | 145 ++++++++++++++
 tb/tb_meas_result_packer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/meas_result_packer.sv
// Measurement record FIFO plus byte serializer.
// Records {mode, mux_chn, data_1, data_2} are queued and then emitted as 8-byte
// frames: header, six data bytes (MSB first), and a modulo-256 checksum.
module meas_result_packer #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [2:0]                mode,
  input  logic [2:0]                mux_chn,
  input  logic [DATA_WIDTH-1:0]     data_1,
  input  logic [DATA_WIDTH-1:0]     data_2,
  input  logic                      clr_ovf,
  output logic [7:0]                out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int REC_W = 6 + 2 * DATA_WIDTH;

  typedef enum logic {IDLE, SEND} state_t;

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [REC_W-1:0] hold_q, hold_d;

  logic             push, pop, drop, xfer;
  logic [7:0]       hdr, csum, byte_sel;

  // Status flags come only from the registered count, never from this cycle's wr_en.
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = ovf_q;

  // Output byte is driven straight from the holding register and byte index.
  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? byte_sel : 8'h00;

  // Frame byte selection and checksum over the first seven bytes.
  always_comb begin
    hdr  = {2'b10, hold_q[53:48]};
    csum = hdr + hold_q[47:40] + hold_q[39:32] + hold_q[31:24]
         + hold_q[23:16] + hold_q[15:8] + hold_q[7:0];
    case (idx_q)
      3'd0:    byte_sel = hdr;
      3'd1:    byte_sel = hold_q[47:40];
      3'd2:    byte_sel = hold_q[39:32];
      3'd3:    byte_sel = hold_q[31:24];
      3'd4:    byte_sel = hold_q[23:16];
      3'd5:    byte_sel = hold_q[15:8];
      3'd6:    byte_sel = hold_q[7:0];
      default: byte_sel = csum;
    endcase
  end

  // Serializer next-state plus FIFO pointer/count/overflow bookkeeping.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    pop      = 1'b0;
    xfer     = (state_q == SEND) && out_ready;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          hold_d  = mem_q[rd_ptr_q];
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
            // Chain straight into the next record so frames stream without a gap.
            if (!empty) begin
              pop    = 1'b1;
              hold_d = mem_q[rd_ptr_q];
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
    push     = wr_en && !full;
    drop     = wr_en && full;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    // A drop in the same cycle as a clear wins, so no lost record goes unreported.
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  // Record storage; contents need no reset since pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {mode, mux_chn, data_1, data_2};
  end

  // State registers with synchronous reset; reset also abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: tb/tb_meas_result_packer.sv
// Bench for meas_result_packer: queue-based reference model stepped each rising
// edge, outputs compared on the falling edge.
module tb_meas_result_packer;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, wr_en, clr_ovf, out_ready;
  logic [2:0]    mode, mux_chn;
  logic [23:0]   data_1, data_2;
  logic [7:0]    out_data;
  logic          out_valid, full, empty, overflow;
  logic [CW-1:0] count;
  logic [CW+11:0] dut_vec;

  int checks   = 0;
  int failures = 0;

  meas_result_packer #(.DATA_WIDTH(24), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .mode(mode), .mux_chn(mux_chn),
    .data_1(data_1), .data_2(data_2), .clr_ovf(clr_ovf),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  assign dut_vec = {out_valid, out_data, count, full, empty, overflow};

  // Reference model: queue of stored records, queue of bytes of the frame in flight.
  logic [53:0] m_fifo [$];
  logic [7:0]  m_cur  [$];
  bit          m_ovf;

  function automatic logic [CW+11:0] model_vec();
    logic       v;
    logic [7:0] d;
    v = (m_cur.size() != 0);
    d = v ? m_cur[0] : 8'h00;
    return {v, d, CW'(m_fifo.size()), m_fifo.size() == DEPTH, m_fifo.size() == 0, m_ovf};
  endfunction

  task automatic model_step();
    bit          xf, pp, dr;
    logic [53:0] r;
    int          s;
    logic [7:0]  b;
    if (rst) begin
      m_fifo.delete(); m_cur.delete(); m_ovf = 0;
      return;
    end
    xf = (m_cur.size() != 0) && out_ready;
    pp = (m_fifo.size() != 0) && ((m_cur.size() == 0) || (xf && m_cur.size() == 1));
    dr = wr_en && (m_fifo.size() == DEPTH);
    if (xf) void'(m_cur.pop_front());
    if (pp) begin
      r = m_fifo.pop_front();
      b = {2'b10, r[53:48]};
      m_cur.push_back(b);
      s = b;
      for (int k = 1; k < 7; k++) begin
        b = r[55-8*k -: 8];
        m_cur.push_back(b);
        s += b;
      end
      m_cur.push_back(8'(s % 256));
    end
    if (wr_en && !dr) m_fifo.push_back({mode, mux_chn, data_1, data_2});
    if (dr) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic rand_rec();
    mode    = 3'($urandom);
    mux_chn = 3'($urandom);
    data_1  = 24'($urandom);
    data_2  = 24'($urandom);
  endtask

  task automatic flush();
    wr_en = 0; clr_ovf = 0; rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; wr_en = 0; clr_ovf = 0; out_ready = 0;
    mode = 0; mux_chn = 0; data_1 = 0; data_2 = 0;
    tick(); tick();
    rst = 0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
    checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ({full, empty, overflow} !== 3'b010) begin failures++; $display("FAIL reset_flags got=%b exp=010", {full, empty, overflow}); end
  endtask

  task automatic test_single();
    logic [7:0] exp [8] = '{8'h8A, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'h8D};
    flush();
    out_ready = 1;
    mode = 3'd1; mux_chn = 3'd2; data_1 = 24'h123456; data_2 = 24'hABCDEF;
    wr_en = 1;
    tick();
    wr_en = 0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid_latency got=%b exp=1", out_valid); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_data !== exp[i]) begin failures++; $display("FAIL single_byte%0d got=%h exp=%h", i, out_data, exp[i]); end
      checks++; if (dut_vec !== model_vec()) begin failures++; $display("FAIL single_vec%0d got=%h exp=%h", i, dut_vec, model_vec()); end
      tick();
    end
    checks++; if ({out_valid, empty} !== 2'b01) begin failures++; $display("FAIL single_done got=%b exp=01", {out_valid, empty}); end
  endtask

  task automatic test_full();
    int n, nbytes;
    flush();
    out_ready = 0;
    // First record moves into the serializer and stalls there.
    rand_rec(); wr_en = 1; tick();
    wr_en = 0; tick();
    for (int i = 0; i < DEPTH + 1; i++) begin
      rand_rec(); wr_en = 1; tick();
    end
    wr_en = 0;
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", full); end
    checks++; if (count !== CW'(DEPTH)) begin failures++; $display("FAIL full_count got=%0d exp=%0d", count, DEPTH); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL full_ovf got=%b exp=1", overflow); end
    checks++; if (dut_vec !== model_vec()) begin failures++; $display("FAIL full_vec got=%h exp=%h", dut_vec, model_vec()); end
    // Clear coinciding with another drop leaves the flag set.
    rand_rec(); wr_en = 1; clr_ovf = 1; tick();
    wr_en = 0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL clr_vs_drop got=%b exp=1", overflow); end
    tick();
    clr_ovf = 0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL clr_ovf got=%b exp=0", overflow); end
    out_ready = 1;
    n = 0; nbytes = 0;
    while ((out_valid || !empty) && n < 8 * (DEPTH + 2) + 10) begin
      checks++; if (dut_vec !== model_vec()) begin failures++; $display("FAIL drain_vec%0d got=%h exp=%h", n, dut_vec, model_vec()); end
      if (out_valid) nbytes++;
      tick(); n++;
    end
    checks++; if (n >= 8 * (DEPTH + 2) + 10) begin failures++; $display("FAIL drain_timeout got=%0d exp<%0d", n, 8 * (DEPTH + 2) + 10); end
    checks++; if (nbytes != 8 * (DEPTH + 1)) begin failures++; $display("FAIL drain_bytes got=%0d exp=%0d", nbytes, 8 * (DEPTH + 1)); end
  endtask

  task automatic test_same_cycle();
    flush();
    out_ready = 0;
    rand_rec(); wr_en = 1; tick();
    wr_en = 0; tick();
    for (int i = 0; i < DEPTH - 1; i++) begin
      rand_rec(); wr_en = 1; tick();
    end
    wr_en = 0;
    checks++; if (count !== CW'(DEPTH - 1)) begin failures++; $display("FAIL sc_setup_count got=%0d exp=%0d", count, DEPTH - 1); end
    out_ready = 1;
    repeat (7) tick();
    rand_rec(); wr_en = 1; tick();
    wr_en = 0; out_ready = 0;
    checks++; if (count !== CW'(DEPTH - 1)) begin failures++; $display("FAIL sc_notfull_count got=%0d exp=%0d", count, DEPTH - 1); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL sc_notfull_ovf got=%b exp=0", overflow); end
    checks++; if (dut_vec !== model_vec()) begin failures++; $display("FAIL sc_notfull_vec got=%h exp=%h", dut_vec, model_vec()); end
    rand_rec(); wr_en = 1; tick();
    wr_en = 0;
    checks++; if (count !== CW'(DEPTH)) begin failures++; $display("FAIL sc_fill_count got=%0d exp=%0d", count, DEPTH); end
    out_ready = 1;
    repeat (7) tick();
    // Pop goes ahead while the push is dropped, so the record count drops by one.
    rand_rec(); wr_en = 1; tick();
    wr_en = 0; out_ready = 0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL sc_full_ovf got=%b exp=1", overflow); end
    checks++; if (count !== CW'(DEPTH - 1)) begin failures++; $display("FAIL sc_full_count got=%0d exp=%0d", count, DEPTH - 1); end
    checks++; if (dut_vec !== model_vec()) begin failures++; $display("FAIL sc_full_vec got=%h exp=%h", dut_vec, model_vec()); end
  endtask

  task automatic test_random_ready();
    logic       pv, pr;
    logic [7:0] pd;
    flush();
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      wr_en     = ($urandom_range(0, 9) == 0);
      clr_ovf   = ($urandom_range(0, 31) == 0);
      rand_rec();
      pv = out_valid; pr = out_ready; pd = out_data;
      tick();
      if (pv && !pr) begin
        checks++; if ({out_valid, out_data} !== {1'b1, pd}) begin failures++; $display("FAIL rand_hold%0d got=%b/%h exp=1/%h", c, out_valid, out_data, pd); end
      end
      checks++; if (dut_vec !== model_vec()) begin failures++; $display("FAIL rand_vec%0d got=%h exp=%h", c, dut_vec, model_vec()); end
    end
    wr_en = 0; clr_ovf = 0;
  endtask

  task automatic test_back_to_back();
    bit v [32];
    int total, first, run;
    flush();
    out_ready = 1;
    for (int c = 0; c < 32; c++) begin
      wr_en = (c < 3);
      rand_rec();
      tick();
      v[c] = out_valid;
      checks++; if (dut_vec !== model_vec()) begin failures++; $display("FAIL b2b_vec%0d got=%h exp=%h", c, dut_vec, model_vec()); end
    end
    wr_en = 0;
    total = 0; first = -1; run = 0;
    for (int c = 0; c < 32; c++) begin
      if (v[c]) begin
        total++;
        if (first < 0) first = c;
      end
    end
    for (int c = (first < 0 ? 0 : first); c < 32 && v[c]; c++) run++;
    checks++; if (first != 1) begin failures++; $display("FAIL b2b_first got=%0d exp=1", first); end
    checks++; if (total != 24) begin failures++; $display("FAIL b2b_total got=%0d exp=24", total); end
    checks++; if (run != 24) begin failures++; $display("FAIL b2b_run got=%0d exp=24", run); end
  endtask

  task automatic test_reset_mid();
    flush();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      rand_rec(); wr_en = 1; tick();
    end
    wr_en = 0;
    checks++; if (count !== CW'(2)) begin failures++; $display("FAIL rm_queued got=%0d exp=2", count); end
    out_ready = 1;
    repeat (3) tick();
    checks++; if (dut_vec !== model_vec()) begin failures++; $display("FAIL rm_idx3_vec got=%h exp=%h", dut_vec, model_vec()); end
    rst = 1; tick();
    rst = 0;
    checks++; if ({out_valid, empty} !== 2'b01) begin failures++; $display("FAIL rm_after_rst got=%b exp=01", {out_valid, empty}); end
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_quiet%0d got=%b exp=0", c, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_same_cycle();
    test_random_ready();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
